// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and instruction-memory write bus of the program loader
interface prog_loader_if #(
  parameter int AW = 10
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a length-prefixed little-endian byte stream into instruction memory
// and holds the core in reset until the image is complete.
module prog_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  prog_loader_if.slave  bus,
  output logic          core_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] len;
  logic [1:0]  bcnt;
  logic [31:0] word;
  logic [AW:0] widx;
  logic [AW:0] widx_inc;
  logic        take;
  logic        done_q;
  logic        err_q;

  // Gating with rst keeps in_ready low while reset is held, yet high right after release.
  assign bus.in_ready   = rst & ((state == LEN_LO) || (state == LEN_HI) || (state == DATA));
  assign take           = bus.in_valid & bus.in_ready;
  assign widx_inc       = widx + 1'b1;
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_addr  = widx[AW-1:0];
  assign bus.imem_wdata = word;
  assign words_loaded   = widx;
  assign done           = done_q;
  assign err            = err_q;
  assign core_hold      = ~done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LEN_LO;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LEN_LO: begin
        if (take) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (take) begin
          if ({bus.in_data, len[7:0]} == 16'd0) begin
            state_nxt = DONE;
          end else if ({1'b0, bus.in_data, len[7:0]} > DEPTH_L) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (take && (bcnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (16'(widx_inc) == len) ? DONE : DATA;
      end
      DONE, ERR: begin
        if (restart) state_nxt = LEN_LO;
      end
      default: state_nxt = LEN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len    <= '0;
      bcnt   <= '0;
      word   <= '0;
      widx   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state_nxt == DONE);
      err_q  <= (state_nxt == ERR);
      case (state)
        LEN_LO: begin
          if (take) len[7:0] <= bus.in_data;
        end
        LEN_HI: begin
          if (take) begin
            len[15:8] <= bus.in_data;
            bcnt      <= '0;
            widx      <= '0;
          end
        end
        DATA: begin
          if (take) begin
            word[{bcnt, 3'b000} +: 8] <= bus.in_data;
            bcnt                      <= bcnt + 2'd1;
          end
        end
        WRITE: begin
          widx <= widx_inc;
        end
        DONE, ERR: begin
          if (restart) begin
            len  <= '0;
            bcnt <= '0;
            widx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven and randomized checks of prog_loader against a stream-level model
module tb_prog_loader;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        restart = 1'b0;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [AW:0] words_loaded;

  prog_loader_if #(.AW(AW)) bus ();

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .bus          (bus),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] got_a[$];
  logic [31:0]   got_d[$];
  int            ready_in_write = 0;

  logic [AW-1:0] exp_a[$];
  logic [31:0]   exp_d[$];
  bit            exp_done;
  bit            exp_err;
  int            exp_words;

  logic [7:0]    q[$];

  typedef struct {
    logic [127:0] bytes;
    int           n;
    bit           rnd;
    bit           e_done;
    bit           e_err;
    int           e_words;
    logic [31:0]  e_w0;
  } vec_t;

  vec_t vt[7];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      got_a.push_back(bus.imem_addr);
      got_d.push_back(bus.imem_wdata);
      if (bus.in_ready) ready_in_write++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected writes straight from the stream format: 16-bit LE length, then LE 32-bit words.
  function automatic void model(input logic [7:0] s[$]);
    int len;
    exp_a.delete();
    exp_d.delete();
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 0;
    len = int'(s[0]) + 256 * int'(s[1]);
    if (len == 0) begin
      exp_done = 1'b1;
    end else if (len > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < len; w++) begin
        exp_a.push_back(AW'(w));
        exp_d.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
      end
      exp_done  = 1'b1;
      exp_words = len;
    end
  endfunction

  task automatic send(input logic [7:0] s[$], input bit rnd);
    int i = 0;
    int budget;
    bit accepted;
    budget = 40 * s.size() + 100;
    while (i < s.size() && budget > 0) begin
      @(negedge clk);
      bus.in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = (rnd && !bus.in_valid) ? 8'($urandom) : s[i];
      restart      = rnd && ($urandom_range(0, 7) == 0);
      accepted     = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (accepted) i++;
      budget--;
    end
    #1;
    bus.in_valid = 1'b0;
    restart      = 1'b0;
    if (i < s.size()) chk("send_timeout", i, s.size());
  endtask

  task automatic run(input logic [7:0] s[$], input bit rnd, input string tag,
                     input bit e_done, input bit e_err, input int e_words);
    int bad = 0;
    got_a.delete();
    got_d.delete();
    ready_in_write = 0;
    model(s);
    send(s, rnd);
    @(negedge clk);
    if (e_words > 0) begin
      chk({tag, "_we_after_last"}, bus.imem_we, 1);
      chk({tag, "_last_addr"}, bus.imem_addr, e_words - 1);
      chk({tag, "_hold_in_write"}, core_hold, 1);
      @(negedge clk);
    end
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_core_hold"}, core_hold, !e_done);
    chk({tag, "_ready_idle"}, bus.in_ready, 0);
    chk({tag, "_words"}, words_loaded, e_words);
    chk({tag, "_nwrites"}, got_a.size(), exp_a.size());
    for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
      if (got_a[k] !== exp_a[k] || got_d[k] !== exp_d[k]) begin
        if (bad == 0)
          $display("FAIL %s_write%0d: got addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                   tag, k, got_a[k], got_d[k], exp_a[k], exp_d[k]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    chk({tag, "_ready_in_write"}, ready_in_write, 0);
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    chk({tag, "_rs_ready"}, bus.in_ready, 1);
    chk({tag, "_rs_hold"}, core_hold, 1);
    chk({tag, "_rs_flags"}, {done, err}, 2'b00);
    chk({tag, "_rs_words"}, words_loaded, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vt[0] = '{128'h02001305_A0009305_B0000000_00000000, 10, 1'b0, 1'b1, 1'b0, 2, 32'h00A00513};
    vt[1] = '{128'h0,                                     2, 1'b0, 1'b1, 1'b0, 0, 32'h0};
    vt[2] = '{128'h01040000_00000000_00000000_00000000,  2, 1'b0, 1'b0, 1'b1, 0, 32'h0};
    vt[3] = '{128'h03001122_33445566_778899AA_BBCC0000, 14, 1'b1, 1'b1, 1'b0, 3, 32'h44332211};
    vt[4] = '{128'h03001122_33445566_778899AA_BBCC0000, 14, 1'b0, 1'b1, 1'b0, 3, 32'h44332211};
    vt[5] = '{128'h00050000_00000000_00000000_00000000,  2, 1'b0, 1'b0, 1'b1, 0, 32'h0};
    vt[6] = '{128'hFFFF0000_00000000_00000000_00000000,  2, 1'b1, 1'b0, 1'b1, 0, 32'h0};

    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_imem_wdata", bus.imem_wdata, 0);
    chk("rst_core_hold", core_hold, 1);
    chk("rst_flags", {done, err}, 2'b00);
    chk("rst_words", words_loaded, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("post_rst_ready", bus.in_ready, 1);

    for (int v = 0; v < 7; v++) begin
      q.delete();
      for (int i = 0; i < vt[v].n; i++) q.push_back(vt[v].bytes[127-8*i -: 8]);
      run(q, vt[v].rnd, $sformatf("vec%0d", v), vt[v].e_done, vt[v].e_err, vt[v].e_words);
      if (vt[v].e_words > 0) chk($sformatf("vec%0d_word0", v), got_d[0], vt[v].e_w0);
    end

    for (int r = 0; r < 20; r++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      q.delete();
      q.push_back(8'(len));
      q.push_back(8'(len >> 8));
      for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
      model(q);
      run(q, 1'b1, $sformatf("rand%0d", r), exp_done, exp_err, exp_words);
    end

    // Reset two bytes into word 1 of a 4-word load, then a clean 1-word load.
    q = '{8'h04, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h66};
    send(q, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_we", bus.imem_we, 0);
    chk("abort_ready", bus.in_ready, 0);
    chk("abort_hold", core_hold, 1);
    chk("abort_words", words_loaded, 0);
    chk("abort_wdata", bus.imem_wdata, 0);
    got_a.delete();
    got_d.delete();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("abort_no_stray_write", got_a.size(), 0);
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run(q, 1'b0, "after_abort", 1'b1, 1'b0, 1);
    chk("after_abort_data", got_d[0], 32'h44332211);

    q.delete();
    q.push_back(8'h00);
    q.push_back(8'h04);
    for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
    run(q, 1'b0, "full", 1'b1, 1'b0, DEPTH);
    if (got_a.size() > 0) chk("full_last_addr", got_a[got_a.size()-1], DEPTH - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
